// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and fetch constants.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam int unsigned PC_INCR  = 4;

endpackage

// File: rtl/if_fetch_unit_skid.sv
// One-entry skid register plus the mux that picks the live memory word, the held word or NOP.
module fetch_skid_buffer #(
  parameter int unsigned     n   = 32,
  parameter logic [n-1:0]    NOP = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         flush,
  input  logic         show,
  input  logic         sel_skid,
  input  logic [n-1:0] data,
  output logic [n-1:0] instruction
);

  logic [n-1:0] skid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q <= NOP;
    end else if (flush) begin
      skid_q <= NOP;
    end else if (load) begin
      skid_q <= data;
    end
  end

  always_comb begin
    instruction = NOP;
    if (show) begin
      instruction = sel_skid ? skid_q : data;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, drives synchronous-read imem, and feeds IF/ID with stall and redirect support.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned  n        = 32,
  parameter logic [n-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [n-1:0] NOP      = NOP_WORD
) (
  input  logic         clk,
  input  logic         reset_in,
  input  logic         enable,
  input  logic         branch_taken_in,
  input  logic [n-1:0] branch_target_in,
  input  logic         jump_in,
  input  logic [25:0]  jump_offset_in,
  input  logic [n-1:0] id_pc_plus4_in,
  output logic [n-1:0] imem_addr_out,
  input  logic [n-1:0] imem_data_in,
  output logic [n-1:0] PC_Counter_out,
  output logic [n-1:0] instruction_out,
  output logic         valid_out
);

  localparam logic [n-1:0] INCR = n'(PC_INCR);

  fetch_state_t state_q, state_d;
  logic [n-1:0] pc_q, pc_d;
  logic [n-1:0] pend_pc_q, pend_pc_d;
  logic [n-1:0] target;
  logic         redirect;
  logic         skid_load;
  logic         show;
  logic         sel_skid;
  logic         unused_bits;

  assign unused_bits = ^{id_pc_plus4_in[n-5:0], branch_target_in[1:0]};

  assign redirect = jump_in | branch_taken_in;
  assign target   = jump_in ? {id_pc_plus4_in[n-1:n-4], jump_offset_in, 2'b00}
                            : {branch_target_in[n-1:2], 2'b00};

  // A redirect wins over enable and over the current state; the skid word is dropped.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    skid_load = 1'b0;
    if (redirect) begin
      pc_d    = target;
      state_d = FILL;
    end else begin
      unique case (state_q)
        FILL: begin
          pend_pc_d = pc_q;
          pc_d      = pc_q + INCR;
          state_d   = RUN;
        end
        RUN: begin
          if (enable) begin
            pend_pc_d = pc_q;
            pc_d      = pc_q + INCR;
          end else begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end
        end
        HOLD: begin
          if (enable) begin
            pend_pc_d = pc_q;
            pc_d      = pc_q + INCR;
            state_d   = RUN;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= FILL;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign show     = (state_q != FILL);
  assign sel_skid = (state_q == HOLD);

  fetch_skid_buffer #(
    .n   (n),
    .NOP (NOP)
  ) u_skid (
    .clk         (clk),
    .rst         (reset_in),
    .load        (skid_load),
    .flush       (redirect),
    .show        (show),
    .sel_skid    (sel_skid),
    .data        (imem_data_in),
    .instruction (instruction_out)
  );

  assign imem_addr_out  = pc_q;
  assign valid_out      = show;
  assign PC_Counter_out = show ? pend_pc_q + INCR : '0;

endmodule
